// File: rtl/window_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_scan_ctrl: raster-order 3x3 window read sequencer with valid/ready  |
// | hand-off. Optional macro WIN_STRIDE2_EN selects a stride-2 centre scan.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module window_scan_ctrl #(
  parameter int DW       = 8,
  parameter int OUT_DW   = 3*DW,
  parameter int MEM_ADDR = 5,
  parameter int IMG_SIZE = 28,
  parameter int CNT_W    = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic                busy_o,
  output logic                rd_en_o,
  output logic [MEM_ADDR-1:0] a_add_row_o,
  output logic [MEM_ADDR-1:0] a_add_col_o,
  input  logic [OUT_DW-1:0]   mem_out_a_i,
  input  logic [OUT_DW-1:0]   mem_out_b_i,
  input  logic [OUT_DW-1:0]   mem_out_c_i,
  output logic                win_valid_o,
  input  logic                win_ready_i,
  output logic [OUT_DW-1:0]   win_a_o,
  output logic [OUT_DW-1:0]   win_b_o,
  output logic [OUT_DW-1:0]   win_c_o,
  output logic [MEM_ADDR-1:0] win_row_o,
  output logic [MEM_ADDR-1:0] win_col_o,
  output logic [CNT_W-1:0]    win_count_o,
  output logic                done_o
);

`ifdef WIN_STRIDE2_EN
  localparam int c_STEP_I = 2;
  localparam int c_LAST_I = ((IMG_SIZE % 2) == 1) ? IMG_SIZE : IMG_SIZE - 1;
`else
  localparam int c_STEP_I = 1;
  localparam int c_LAST_I = IMG_SIZE;
`endif

  localparam logic [MEM_ADDR-1:0] c_STEP  = MEM_ADDR'(c_STEP_I);
  localparam logic [MEM_ADDR-1:0] c_LAST  = MEM_ADDR'(c_LAST_I);
  localparam logic [MEM_ADDR-1:0] c_FIRST = MEM_ADDR'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                rd_en_q;
  logic [MEM_ADDR-1:0] row_q;
  logic [MEM_ADDR-1:0] col_q;
  logic                win_valid_q;
  logic [OUT_DW-1:0]   win_a_q;
  logic [OUT_DW-1:0]   win_b_q;
  logic [OUT_DW-1:0]   win_c_q;
  logic [MEM_ADDR-1:0] win_row_q;
  logic [MEM_ADDR-1:0] win_col_q;
  logic [CNT_W-1:0]    win_count_q;
  logic                done_q;

  logic                w_load;
  logic                w_xfer;
  logic                w_last;
  logic [MEM_ADDR-1:0] row_d;
  logic [MEM_ADDR-1:0] col_d;

  always_comb begin
    w_load = !win_valid_q || win_ready_i;
    w_xfer = win_valid_q && win_ready_i;
    w_last = (row_q == c_LAST) && (col_q == c_LAST);
    row_d  = row_q;
    col_d  = col_q + c_STEP;
    if (col_q == c_LAST) begin
      col_d = c_FIRST;
      row_d = row_q + c_STEP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_a_q     <= '0;
      win_b_q     <= '0;
      win_c_q     <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q     <= S_SCAN;
            busy_q      <= 1'b1;
            rd_en_q     <= 1'b1;
            row_q       <= c_FIRST;
            col_q       <= c_FIRST;
            win_count_q <= '0;
          end
        end
        S_SCAN: begin
          if (w_xfer) begin
            win_count_q <= win_count_q + CNT_W'(1);
          end
          // Capture may overlap a transfer, giving one window per clock.
          if (w_load) begin
            win_a_q     <= mem_out_a_i;
            win_b_q     <= mem_out_b_i;
            win_c_q     <= mem_out_c_i;
            win_row_q   <= row_q;
            win_col_q   <= col_q;
            win_valid_q <= 1'b1;
            if (w_last) begin
              state_q <= S_DRAIN;
              rd_en_q <= 1'b0;
              row_q   <= '0;
              col_q   <= '0;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            win_count_q <= win_count_q + CNT_W'(1);
            win_valid_q <= 1'b0;
            state_q     <= S_DONE;
            done_q      <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign rd_en_o     = rd_en_q;
  assign a_add_row_o = row_q;
  assign a_add_col_o = col_q;
  assign win_valid_o = win_valid_q;
  assign win_a_o     = win_a_q;
  assign win_b_o     = win_b_q;
  assign win_c_o     = win_c_q;
  assign win_row_o   = win_row_q;
  assign win_col_o   = win_col_q;
  assign win_count_o = win_count_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
`default_nettype none
// Scoreboard bench for window_scan_ctrl: a queue of expected windows built from
// the raster-scan rules is drained by a monitor that watches each hand-off.
module tb_window_scan_ctrl;

  localparam int DW = 8;
  localparam int OUT_DW = 3*DW;
  localparam int MEM_ADDR = 5;
  localparam int IMG_SIZE = 28;
  localparam int CNT_W = 10;
`ifdef WIN_STRIDE2_EN
  localparam int STEP = 2;
  localparam int LAST = ((IMG_SIZE % 2) == 1) ? IMG_SIZE : IMG_SIZE - 1;
`else
  localparam int STEP = 1;
  localparam int LAST = IMG_SIZE;
`endif
  localparam int PER_AXIS = (LAST - 1) / STEP + 1;
  localparam int N_WIN = PER_AXIS * PER_AXIS;

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  logic                start_i = 1'b0;
  logic                win_ready_i = 1'b0;
  logic                busy_o, rd_en_o, win_valid_o, done_o;
  logic [MEM_ADDR-1:0] a_add_row_o, a_add_col_o, win_row_o, win_col_o;
  logic [OUT_DW-1:0]   mem_a, mem_b, mem_c, win_a_o, win_b_o, win_c_o;
  logic [CNT_W-1:0]    win_count_o;

  window_scan_ctrl #(
    .DW(DW), .OUT_DW(OUT_DW), .MEM_ADDR(MEM_ADDR), .IMG_SIZE(IMG_SIZE), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .rd_en_o(rd_en_o),
    .a_add_row_o(a_add_row_o), .a_add_col_o(a_add_col_o),
    .mem_out_a_i(mem_a), .mem_out_b_i(mem_b), .mem_out_c_i(mem_c),
    .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
    .win_a_o(win_a_o), .win_b_o(win_b_o), .win_c_o(win_c_o),
    .win_row_o(win_row_o), .win_col_o(win_col_o),
    .win_count_o(win_count_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(int r, int c);
    return 8'((((r * 30 + c) % 256) + 256) % 256);
  endfunction

  function automatic logic [OUT_DW-1:0] mrow(int r, int c);
    return {pix(r, c - 1), pix(r, c), pix(r, c + 1)};
  endfunction

  // Feature-map memory: combinational read of the three window rows.
  always_comb begin
    mem_a = mrow(int'(a_add_row_o) - 1, int'(a_add_col_o));
    mem_b = mrow(int'(a_add_row_o),     int'(a_add_col_o));
    mem_c = mrow(int'(a_add_row_o) + 1, int'(a_add_col_o));
  end

  typedef struct {
    int r;
    int c;
    logic [OUT_DW-1:0] a;
    logic [OUT_DW-1:0] b;
    logic [OUT_DW-1:0] cc;
  } win_t;

  win_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  int   mode = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_expected();
    win_t w;
    exp_q.delete();
    for (int r = 1; r <= LAST; r += STEP) begin
      for (int c = 1; c <= LAST; c += STEP) begin
        w.r = r; w.c = c;
        w.a = mrow(r - 1, c); w.b = mrow(r, c); w.cc = mrow(r + 1, c);
        exp_q.push_back(w);
      end
    end
  endtask

  // Ready driver: 0 always ready, 1 toggling, 2 random, 3 held low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: win_ready_i = 1'b1;
        1: win_ready_i = ~win_ready_i;
        2: win_ready_i = 1'($urandom_range(0, 1));
        default: win_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: pops one expected window per hand-off and checks stall stability.
  initial begin
    win_t w;
    logic held;
    logic [OUT_DW*3+2*MEM_ADDR-1:0] held_v, cur_v;
    held = 1'b0;
    held_v = '0;
    forever begin
      @(negedge clk);
      cur_v = {win_a_o, win_b_o, win_c_o, win_row_o, win_col_o};
      if (done_o) done_cnt++;
      if (!rst_ni) begin
        held = 1'b0;
      end else if (win_valid_o && !win_ready_i) begin
        if (held) begin
          check("stall_stable_rows", 64'(cur_v[OUT_DW*3+2*MEM_ADDR-1:2*MEM_ADDR] ^ held_v[OUT_DW*3+2*MEM_ADDR-1:2*MEM_ADDR]), 64'd0);
          check("stall_stable_centre", 64'(cur_v[2*MEM_ADDR-1:0]), 64'(held_v[2*MEM_ADDR-1:0]));
        end
        held = 1'b1;
        held_v = cur_v;
      end else begin
        held = 1'b0;
        if (win_valid_o && win_ready_i) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_window", 64'(xfer_cnt), 64'd0);
          end else begin
            w = exp_q.pop_front();
            check("win_centre", {win_row_o, win_col_o}, 64'((w.r << MEM_ADDR) | w.c));
            check("win_a", 64'(win_a_o), 64'(w.a));
            check("win_b", 64'(win_b_o), 64'(w.b));
            check("win_c", 64'(win_c_o), 64'(w.cc));
          end
        end
      end
    end
  end

  task automatic start_scan();
    @(posedge clk); #1;
    start_i = 1'b1;
    xfer_cnt = 0;
    done_cnt = 0;
    build_expected();
    @(posedge clk); #1;
    start_i = 1'b0;
    check("after_start_busy", busy_o, 1);
    check("after_start_rd_en", rd_en_o, 1);
    check("after_start_valid", win_valid_o, 0);
    check("after_start_addr", {a_add_row_o, a_add_col_o}, 64'((1 << MEM_ADDR) | 1));
    check("after_start_count", win_count_o, 0);
    @(posedge clk); #1;
    check("first_valid", win_valid_o, 1);
    check("first_centre", {win_row_o, win_col_o}, 64'((1 << MEM_ADDR) | 1));
    check("first_win_b", win_b_o, 64'h1E1F20);
  endtask

  task automatic wait_done(int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) break;
    end
    check("done_seen", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("final_count", win_count_o, N_WIN);
    check("transfers", xfer_cnt, N_WIN);
    check("queue_empty", exp_q.size(), 0);
    check("idle_busy", busy_o, 0);
    check("idle_valid", win_valid_o, 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_rd_en"}, rd_en_o, 0);
    check({tag, "_addr"}, {a_add_row_o, a_add_col_o}, 0);
    check({tag, "_valid"}, win_valid_o, 0);
    check({tag, "_rows"}, 64'(win_a_o | win_b_o | win_c_o), 0);
    check({tag, "_centre"}, {win_row_o, win_col_o}, 0);
    check({tag, "_count"}, win_count_o, 0);
    check({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Full scan, always ready.
    mode = 0;
    start_scan();
    wait_done(4 * N_WIN);

    // Toggling ready.
    mode = 1;
    start_scan();
    wait_done(4 * N_WIN);

    // Long stall on the first window.
    mode = 3;
    start_scan();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", win_valid_o, 1);
      check("stall_addr", {a_add_row_o, a_add_col_o}, 64'((1 << MEM_ADDR) | (1 + STEP)));
    end
    mode = 0;
    wait_done(4 * N_WIN);

    // Random ready with start pulses mid-scan.
    mode = 2;
    start_scan();
    for (int k = 0; k < 4; k++) begin
      repeat (40) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    wait_done(6 * N_WIN);

    // Start pulsed while reset is held.
    @(posedge clk); #1;
    rst_ni = 1'b0;
    start_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 start_i = 1'b0;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("start_in_reset");

    // Reset mid-scan, then restart.
    mode = 0;
    start_scan();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (xfer_cnt >= 100) break;
    end
    check("reached_100", xfer_cnt >= 100, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_idle", busy_o, 0);
    start_scan();
    wait_done(4 * N_WIN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
